// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined unsigned multiply-add / multiply-accumulate.
// Stage 1 registers the raw product and the beat's side information; stage 2
// adds either C or the running accumulator, then saturates or wraps the sum.
// OUT_WIDTH must be at least 2*WIDTH so that the product always fits.
module mac_pipe #(
   parameter int WIDTH     = 8,
   parameter int OUT_WIDTH = 18,
   parameter int SATURATE  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 mode,
   input  logic                 acc_clr,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [WIDTH-1:0]     C,
   output logic [OUT_WIDTH-1:0] DATA_OUT,
   output logic                 out_valid,
   output logic                 overflow
);

   localparam int PW = 2 * WIDTH;     // product width
   localparam int SW = OUT_WIDTH + 1; // sum width, one carry bit above the result

   // Stage-1 state
   logic [PW-1:0]        prod_q;
   logic [WIDTH-1:0]     c_q;
   logic                 mode_q;
   logic                 clr_q;
   logic                 vld1_q;

   // Stage-2 state and accumulator
   logic [OUT_WIDTH-1:0] data_q;
   logic                 ovf_q;
   logic                 vld2_q;
   logic [OUT_WIDTH-1:0] acc_q;

   // Stage-2 combinational results
   logic [SW-1:0]        prod_ext;
   logic [SW-1:0]        addend;
   logic [SW-1:0]        sum_d;
   logic                 ovf_d;
   logic [OUT_WIDTH-1:0] res_d;
   logic [PW-1:0]        prod_d;

   // Unsigned product of the incoming operands
   always_comb begin
      prod_d = PW'(A) * PW'(B);
   end

   // Stage 1: capture product, addend and control; data fields only load on a valid beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         c_q    <= '0;
         mode_q <= 1'b0;
         clr_q  <= 1'b0;
         vld1_q <= 1'b0;
      end else begin
         vld1_q <= in_valid;
         if (in_valid) begin
            prod_q <= prod_d;
            c_q    <= C;
            mode_q <= mode;
            clr_q  <= acc_clr;
         end
      end
   end

   // Stage-2 datapath: pick the addend, add, then saturate or wrap.
   // Both operands are below 2^OUT_WIDTH, so the sum exceeds the result range
   // exactly when its carry bit is set.
   always_comb begin
      prod_ext = {{(SW - PW){1'b0}}, prod_q};
      addend   = '0;
      if (mode_q) begin
         if (!clr_q) begin
            addend = {1'b0, acc_q};
         end
      end else begin
         addend = {{(SW - WIDTH){1'b0}}, c_q};
      end
      sum_d = prod_ext + addend;
      ovf_d = sum_d[OUT_WIDTH];
      res_d = sum_d[OUT_WIDTH-1:0];
      if (ovf_d && (SATURATE != 0)) begin
         res_d = '1;
      end
   end

   // Stage 2: publish the result; only ACC beats write back into the accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         ovf_q  <= 1'b0;
         vld2_q <= 1'b0;
         acc_q  <= '0;
      end else begin
         vld2_q <= vld1_q;
         if (vld1_q) begin
            data_q <= res_d;
            ovf_q  <= ovf_d;
            if (mode_q) begin
               acc_q <= res_d;
            end
         end
      end
   end

   assign DATA_OUT  = data_q;
   assign out_valid = vld2_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: scoreboard bench for mac_pipe. Three instances share one
// stimulus stream: 18-bit saturating, 16-bit saturating and 16-bit wrapping.
// Each issued beat pushes hand-computed expectations for every instance;
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_mac_pipe;

   typedef struct {
      int data;
      bit ovf;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        mode = 1'b0;
   logic        acc_clr = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic [7:0]  c = '0;

   logic [17:0] d0;
   logic [15:0] d1;
   logic [15:0] d2;
   logic        v0, v1, v2;
   logic        o0, o1, o2;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[3][$];
   int   last_d[3];
   bit   last_o[3];

   mac_pipe #(.WIDTH(8), .OUT_WIDTH(18), .SATURATE(1)) u_w18 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
      .A(a), .B(b), .C(c), .DATA_OUT(d0), .out_valid(v0), .overflow(o0));

   mac_pipe #(.WIDTH(8), .OUT_WIDTH(16), .SATURATE(1)) u_w16s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
      .A(a), .B(b), .C(c), .DATA_OUT(d1), .out_valid(v1), .overflow(o1));

   mac_pipe #(.WIDTH(8), .OUT_WIDTH(16), .SATURATE(0)) u_w16w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
      .A(a), .B(b), .C(c), .DATA_OUT(d2), .out_valid(v2), .overflow(o2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Compare one instance's outputs against the scoreboard, or check hold when idle
   task automatic mon(input int idx, input bit vld, input int data, input bit ovf);
      exp_t e;
      checks++;
      if (vld) begin
         if (q[idx].size() == 0) begin
            errors++;
            $display("FAIL unexpected_out dut%0d: got out_valid=1 data=%0d, required no output", idx, data);
         end else begin
            e = q[idx].pop_front();
            if (data != e.data || ovf != e.ovf || cyc != e.cyc + 2) begin
               errors++;
               $display("FAIL beat dut%0d: got data=%0d ovf=%0b cyc=%0d, required data=%0d ovf=%0b cyc=%0d",
                        idx, data, ovf, cyc, e.data, e.ovf, e.cyc + 2);
            end else begin
               $display("dut%0d beat data=%0d ovf=%0b cyc=%0d ok", idx, data, ovf, cyc);
            end
         end
         last_d[idx] = data;
         last_o[idx] = ovf;
      end else if (data != last_d[idx] || ovf != last_o[idx]) begin
         errors++;
         $display("FAIL hold dut%0d: got data=%0d ovf=%0b, required data=%0d ovf=%0b",
                  idx, data, ovf, last_d[idx], last_o[idx]);
      end
   endtask

   // Monitor: sample away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, v0, int'(d0), o0);
         mon(1, v1, int'(d1), o1);
         mon(2, v2, int'(d2), o2);
      end else begin
         for (int i = 0; i < 3; i++) begin
            last_d[i] = 0;
            last_o[i] = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data0"}, int'(d0), 0);
      chk({tag, "_data1"}, int'(d1), 0);
      chk({tag, "_data2"}, int'(d2), 0);
      chk({tag, "_vld"}, int'({v0, v1, v2}), 0);
      chk({tag, "_ovf"}, int'({o0, o1, o2}), 0);
   endtask

   // Issue one valid beat and push the expectation for each instance
   task automatic beat(input bit m, input bit clr, input int av, input int bv, input int cv,
                       input int e0, input bit f0, input int e1, input bit f1,
                       input int e2, input bit f2);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      mode     = m;
      acc_clr  = clr;
      a        = av[7:0];
      b        = bv[7:0];
      c        = cv[7:0];
      e.cyc  = cyc;
      e.data = e0; e.ovf = f0; q[0].push_back(e);
      e.data = e1; e.ovf = f1; q[1].push_back(e);
      e.data = e2; e.ovf = f2; q[2].push_back(e);
      $display("issue mode=%0b clr=%0b A=%0d B=%0d C=%0d cyc=%0d", m, clr, av, bv, cv, cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         acc_clr  = 1'b0;
      end
   endtask

   initial begin
      int pend;
      for (int i = 0; i < 3; i++) begin
         last_d[i] = 0;
         last_o[i] = 1'b0;
      end
      #12;
      chk_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Single MADD beat
      beat(0, 0, 3, 4, 5,              17, 0, 17, 0, 17, 0);
      idle(3);

      // Back-to-back MADD
      beat(0, 0, 1, 1, 1,              2, 0, 2, 0, 2, 0);
      beat(0, 0, 2, 2, 2,              6, 0, 6, 0, 6, 0);
      beat(0, 0, 255, 255, 255,        65280, 0, 65280, 0, 65280, 0);
      idle(3);

      // Accumulate with a bubble; C is ignored in ACC mode
      beat(1, 1, 10, 10, 77,           100, 0, 100, 0, 100, 0);
      beat(1, 0, 2, 3, 77,             106, 0, 106, 0, 106, 0);
      idle(1);
      beat(1, 0, 1, 1, 77,             107, 0, 107, 0, 107, 0);
      idle(3);

      // Overflow: saturate vs wrap, then confirm what stays in acc
      beat(0, 0, 255, 255, 255,        65280, 0, 65280, 0, 65280, 0);
      beat(1, 1, 255, 255, 9,          65025, 0, 65025, 0, 65025, 0);
      beat(1, 0, 255, 255, 9,          130050, 0, 65535, 1, 64514, 1);
      beat(1, 0, 0, 0, 9,              130050, 0, 65535, 0, 64514, 0);
      idle(3);

      // Interleave: acc_clr on a MADD beat must not touch acc
      beat(1, 1, 5, 5, 0,              25, 0, 25, 0, 25, 0);
      beat(0, 1, 1, 1, 1,              2, 0, 2, 0, 2, 0);
      beat(1, 0, 2, 2, 0,              29, 0, 29, 0, 29, 0);
      idle(4);

      // Reset with two beats in flight: no output may follow
      @(posedge clk); #1;
      in_valid = 1'b1; mode = 1'b0; acc_clr = 1'b0; a = 8'd7; b = 8'd7; c = 8'd1;
      @(posedge clk); #1;
      a = 8'd9; b = 8'd9;
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk_zero("midreset");
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      idle(4);
      beat(1, 0, 3, 3, 0,              9, 0, 9, 0, 9, 0);
      idle(1);

      // Drain with a bounded wait
      pend = 1;
      for (int i = 0; i < 20 && pend != 0; i++) begin
         @(posedge clk);
         pend = q[0].size() + q[1].size() + q[2].size();
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (q[i].size() != 0) begin
            errors++;
            $display("FAIL drain dut%0d: got %0d pending beats, required 0", i, q[i].size());
         end
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
